// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional leading-zero mask output enabled by defining BCD_BLANK_EN.
module bin_to_bcd_seq #(
    parameter int unsigned N_BITS   = 16,
    parameter int unsigned N_DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [N_BITS-1:0]       bin_in,
    output logic                    busy,
    output logic                    done,
    output logic [4*N_DIGITS-1:0]   bcd_out
`ifdef BCD_BLANK_EN
    ,
    output logic [N_DIGITS-1:0]     blank
`endif
);

    localparam int unsigned CntW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    state_t                  state_q, state_d;
    logic [N_BITS-1:0]       shift_q, shift_d;
    logic [4*N_DIGITS-1:0]   scratch_q, scratch_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [4*N_DIGITS-1:0]   bcd_q, bcd_d;
    logic [4*N_DIGITS-1:0]   adj;
    logic [4*N_DIGITS-1:0]   scratch_nxt;
    logic                    load_result;

    // Add-3 correction on every digit in parallel before the shift.
    for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
        assign adj[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ?
                               scratch_q[4*i +: 4] + 4'd3 : scratch_q[4*i +: 4];
    end

    assign scratch_nxt = {adj[4*N_DIGITS-2:0], shift_q[N_BITS-1]};

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        load_result = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StShift;
                    shift_d   = bin_in;
                    scratch_d = '0;
                    cnt_d     = CntW'(N_BITS - 1);
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                shift_d   = {shift_q[N_BITS-2:0], 1'b0};
                scratch_d = scratch_nxt;
                if (cnt_q == '0) begin
                    state_d     = StDone;
                    bcd_d       = scratch_nxt;
                    load_result = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
        end
    end

    always_comb begin
        busy    = (state_q == StShift);
        done    = (state_q == StDone);
        bcd_out = bcd_q;
    end

`ifdef BCD_BLANK_EN
    logic [N_DIGITS-1:0] blank_q, blank_nxt;
    logic                zero_above;

    // Digit 0 is never blanked so a zero result still shows one digit.
    always_comb begin
        blank_nxt  = '0;
        zero_above = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above && (scratch_nxt[4*i +: 4] == 4'd0);
            blank_nxt[i] = zero_above;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= '0;
        end else if (load_result) begin
            blank_q <= blank_nxt;
        end
    end

    assign blank = blank_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized self-checking bench for bin_to_bcd_seq against an arithmetic model.
module tb_bin_to_bcd_seq;

    localparam int unsigned N_BITS   = 16;
    localparam int unsigned N_DIGITS = 5;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [N_BITS-1:0]     bin_in = '0;
    logic                  busy, done;
    logic [4*N_DIGITS-1:0] bcd_out;
    logic [N_DIGITS-1:0]   blank_obs;

    int tests = 0;
    int fails = 0;

    bin_to_bcd_seq #(.N_BITS(N_BITS), .N_DIGITS(N_DIGITS)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
`ifdef BCD_BLANK_EN
        ,
        .blank   (blank_obs)
`endif
    );

`ifndef BCD_BLANK_EN
    assign blank_obs = '0;
`endif

    always #5 clk = ~clk;

    // Model state: value after the next rising edge.
    int unsigned           m_rem = 0;
    int unsigned           m_val = 0;
    logic                  m_done = 1'b0;
    logic [4*N_DIGITS-1:0] m_bcd = '0;
    logic [N_DIGITS-1:0]   m_blank = '0;

    // Values sampled by the most recent compare.
    logic                  s_done;
    logic [4*N_DIGITS-1:0] s_bcd;
    logic [N_DIGITS-1:0]   s_blank;

    function automatic logic [4*N_DIGITS-1:0] to_bcd(input int unsigned v);
        logic [4*N_DIGITS-1:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        for (int i = 0; i < N_DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [N_DIGITS-1:0] to_blank(input logic [4*N_DIGITS-1:0] b);
        logic [N_DIGITS-1:0] r;
        r = '0;
        for (int i = 1; i < N_DIGITS; i++) begin
            r[i] = (b >> (4*i)) == 0;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("busy", 32'(busy), 32'(m_rem != 0));
        chk("done", 32'(done), 32'(m_done));
        chk("bcd_out", 32'(bcd_out), 32'(m_bcd));
`ifdef BCD_BLANK_EN
        chk("blank", 32'(blank_obs), 32'(m_blank));
`endif
        s_done  = done;
        s_bcd   = bcd_out;
        s_blank = blank_obs;
    endtask

    task automatic model_step(input logic s, input logic [N_BITS-1:0] b);
        m_done = 1'b0;
        if (m_rem != 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_bcd   = to_bcd(m_val);
                m_blank = to_blank(m_bcd);
                m_done  = 1'b1;
            end
        end else if (s) begin
            m_val = b;
            m_rem = N_BITS;
        end
    endtask

    // One clock: check at the falling edge, then drive inputs for the next rising edge.
    task automatic cycle(input logic s, input logic [N_BITS-1:0] b);
        @(negedge clk);
        compare();
        start  = s;
        bin_in = b;
        model_step(s, b);
    endtask

    task automatic run_conv(input logic [N_BITS-1:0] v, input logic [4*N_DIGITS-1:0] exp_bcd,
                            input logic [N_DIGITS-1:0] exp_blank, input bit inject);
        int k;
        int pulses;
        k = 0;
        pulses = 0;
        cycle(1'b1, v);
        for (int n = 1; n <= 30; n++) begin
            cycle((inject && n == 5) ? 1'b1 : 1'b0, (inject && n == 5) ? 16'd1 : 16'($urandom));
            if (s_done) begin
                pulses++;
                if (pulses == 1) begin
                    k = n;
                    chk("conv_bcd", 32'(s_bcd), 32'(exp_bcd));
`ifdef BCD_BLANK_EN
                    chk("conv_blank", 32'(s_blank), 32'(exp_blank));
`endif
                end
            end
        end
        chk("conv_latency", 32'(k), 32'd17);
        chk("conv_pulses", 32'(pulses), 32'd1);
    endtask

    task automatic do_reset_mid();
        @(negedge clk);
        compare();
        rst   = 1'b1;
        start = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", 32'(bcd_out), 32'd0);
        chk("rst_blank", 32'(blank_obs), 32'd0);
        m_rem = 0; m_done = 1'b0; m_bcd = '0; m_blank = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int d1, d2;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_bcd", 32'(bcd_out), 32'd0);
        chk("reset_blank", 32'(blank_obs), 32'd0);
        rst = 1'b0;

        run_conv(16'hFFFF, 20'h65535, 5'b00000, 1'b0);
        run_conv(16'd0, 20'h00000, 5'b11110, 1'b0);
        run_conv(16'd65025, 20'h65025, 5'b00000, 1'b0);
        run_conv(16'd907, 20'h00907, 5'b11000, 1'b0);
        run_conv(16'd4321, 20'h04321, 5'b10000, 1'b1);

        // Reset in the middle of a conversion, then convert again.
        cycle(1'b1, 16'd777);
        for (int n = 0; n < 7; n++) cycle(1'b0, 16'($urandom));
        do_reset_mid();
        for (int n = 0; n < 20; n++) cycle(1'b0, 16'($urandom));
        run_conv(16'd12345, 20'h12345, 5'b00000, 1'b0);

        // Start held high through DONE gives back-to-back conversions.
        d1 = -1;
        d2 = -1;
        cycle(1'b1, 16'd1234);
        for (int n = 1; n <= 40; n++) begin
            cycle(n <= 17 ? 1'b1 : 1'b0, 16'd42);
            if (s_done && d1 < 0) begin
                d1 = n;
                chk("b2b_first", 32'(s_bcd), 32'h01234);
            end else if (s_done && d2 < 0) begin
                d2 = n;
                chk("b2b_second", 32'(s_bcd), 32'h00042);
            end
        end
        chk("b2b_spacing", 32'(d2 - d1), 32'd17);

        for (int n = 0; n < 600; n++) begin
            cycle(($urandom % 4) == 0, 16'($urandom));
        end
        for (int n = 0; n < 20; n++) cycle(1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
